// File: rtl/multicycle_control.sv
// Multicycle CPU controller: IDLE/FETCH/DECODE/EXEC/WB sequencing with fetch timeout and illegal-opcode halt.
// Optional retire counter enabled by MULTICYCLE_CONTROL_RETIRE_CNT_EN.
module multicycle_control #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        reg_write,
  output logic        lui_sel,
  output logic [2:0]  alu_op,
  output logic        halt,
  output logic [2:0]  state
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     r_state;
  logic [5:0] r_opcode;
  logic       r_zero;
  logic [7:0] r_wait;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;
`endif

  logic       w_supported;
  logic       w_is_r, w_is_addi, w_is_ori, w_is_beq, w_is_bne, w_is_lui;
  logic [2:0] w_alu_op;
  logic       w_alu_src;

  assign w_supported = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_ORI) ||
                       (opcode == OP_BEQ)   || (opcode == OP_BNE)  || (opcode == OP_LUI);

  // Datapath controls in EXEC/WB come from the latched opcode, not the live IR bits.
  assign w_is_r    = (r_opcode == OP_RTYPE);
  assign w_is_addi = (r_opcode == OP_ADDI);
  assign w_is_ori  = (r_opcode == OP_ORI);
  assign w_is_beq  = (r_opcode == OP_BEQ);
  assign w_is_bne  = (r_opcode == OP_BNE);
  assign w_is_lui  = (r_opcode == OP_LUI);

  always_comb begin
    w_alu_op = 3'b000;
    if (w_is_r)                 w_alu_op = 3'b111;
    else if (w_is_addi)         w_alu_op = 3'b001;
    else if (w_is_ori)          w_alu_op = 3'b010;
    else if (w_is_beq || w_is_bne) w_alu_op = 3'b011;
  end
  assign w_alu_src = w_is_addi | w_is_ori | w_is_lui;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_opcode <= 6'd0;
      r_zero   <= 1'b0;
      r_wait   <= 8'd0;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
      r_retire_cnt <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_wait  <= 8'd0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_state <= S_DECODE;
            r_wait  <= 8'd0;
          end else if (r_wait == WAIT_LAST) begin
            r_state <= S_HALT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          r_opcode <= opcode;
          r_state  <= w_supported ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          r_zero  <= zero;
          r_state <= S_WB;
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_wait  <= 8'd0;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
          r_retire_cnt <= r_retire_cnt + 32'd1;
`endif
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Outputs decode the state register; only ir_write looks at the live ack.
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_dst   = 1'b0;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    lui_sel   = 1'b0;
    alu_op    = 3'b000;
    halt      = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
      end
      S_EXEC: begin
        alu_op  = w_alu_op;
        alu_src = w_alu_src;
      end
      S_WB: begin
        alu_op    = w_alu_op;
        alu_src   = w_alu_src;
        pc_write  = 1'b1;
        pc_src    = (w_is_beq & r_zero) | (w_is_bne & ~r_zero);
        reg_write = w_is_r | w_is_addi | w_is_ori | w_is_lui;
        reg_dst   = w_is_r;
        lui_sel   = w_is_lui;
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;
`ifdef MULTICYCLE_CONTROL_RETIRE_CNT_EN
  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter FETCH_TIMEOUT, default 15, max FETCH-state cycles without imem_ack before halting (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port opcode  input  6  instruction bits [31:26] from instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port imem_ack  input  1  program memory data valid.
REQ-007 SHALL have port imem_req  output  1  program memory read request.
REQ-008 SHALL have port ir_write  output  1  load instruction register.
REQ-009 SHALL have port pc_write  output  1  update PC register.
REQ-010 SHALL have port pc_src  output  1  0 = PC+4, 1 = branch target.
REQ-011 SHALL have ports reg_dst, alu_src, reg_write, lui_sel  output  1 each  datapath mux/enable controls.
REQ-012 SHALL have port alu_op  output  3  ALU control class.
REQ-013 SHALL have port halt  output  1  controller stopped (illegal opcode or fetch timeout).
REQ-014 SHALL have port state  output  3  current state encoding, for debug.

Function
REQ-015 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6-7 SHALL transition to HALT.
REQ-016 IDLE -> FETCH unconditionally after one cycle.
REQ-017 FETCH: imem_req=1; on imem_ack=1 -> DECODE with ir_write=1 that same cycle (Mealy); ir_write SHALL be 0 in every other cycle.
REQ-018 FETCH wait counter SHALL clear on FETCH entry, increment per no-ack cycle; ack absent for FETCH_TIMEOUT consecutive cycles -> HALT.
REQ-019 DECODE: latch opcode into internal register; supported opcodes 0x00 (R-type), 0x08 addi, 0x0D ori, 0x04 beq, 0x05 bne, 0x0F lui -> EXEC; any other -> HALT.
REQ-020 EXEC: drive alu_op/alu_src from latched opcode; register zero at end of cycle -> WB.
REQ-021 alu_op: R-type=3'b111, addi=3'b001, ori=3'b010, beq/bne=3'b011, lui=3'b000; alu_src=1 for addi/ori/lui, else 0; held stable EXEC and WB.
REQ-022 WB: pc_write=1 for exactly one cycle; pc_src = (beq & zero_q) | (bne & ~zero_q); -> FETCH.
REQ-023 WB: reg_write=1 for R-type, addi, ori, lui; 0 for beq/bne; reg_dst=1 only for R-type; lui_sel=1 only for lui.
REQ-024 Outside WB: reg_write, pc_write, pc_src, lui_sel SHALL be 0; reg_dst 0 outside EXEC/WB.
REQ-025 Zero-wait instruction latency: exactly 4 cycles FETCH->WB; each ack wait cycle adds one.
REQ-026 HALT: halt=1, all other outputs 0, remains until reset.
REQ-027 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, all outputs 0, opcode latch 0, zero_q 0, wait counter 0, regardless of clk, including mid-fetch or in HALT.
REQ-029 First FETCH SHALL occur in the second rising edge after reset release.

Configuration
REQ-030 Macro MULTICYCLE_CONTROL_RETIRE_CNT_EN defined: add output retire_cnt (32 bits), reset 0, increments on each WB cycle, wraps 0xFFFFFFFF -> 0, frozen in HALT.
REQ-031 Macro undefined: retire_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset release, imem_ack tied 1, opcode 0x00: state sequence 0,1,2,3,4,1; reg_write=1 and reg_dst=1 only in WB; pc_write pulse every 4 cycles.
REQ-033 opcode 0x04, zero=1 in EXEC -> WB pc_src=1, reg_write=0; opcode 0x05 with zero=1 -> pc_src=0.
REQ-034 opcode 0x0F -> alu_src=1, alu_op=000, lui_sel=1 and reg_write=1 in WB.
REQ-035 imem_ack held 0 for 15 cycles in FETCH -> state=5, halt=1; ack after 14 cycles -> DECODE, no halt.
REQ-036 opcode 0x23 in DECODE -> HALT; reset pulse low mid-EXEC -> outputs 0 asynchronously, restart at IDLE.
REQ-037 With MULTICYCLE_CONTROL_RETIRE_CNT_EN: 10 zero-wait instructions -> retire_cnt=10; preload 0xFFFFFFFF then one WB -> 0.
